// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file execute stage.
package regfile_pkg;

  localparam int unsigned WORDSIZE = 64;
  localparam int unsigned ADDRW    = 5;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SLT = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } exec_state_t;

endpackage

// File: rtl/regfile_alu.sv
// Combinational ALU for the single-cycle ops; MUL is either iterated in the
// top block (REGFILE_EXEC_MUL_EN) or flagged illegal here.
module regfile_alu
  import regfile_pkg::*;
#(
  parameter int unsigned W = regfile_pkg::WORDSIZE
) (
  input  alu_op_t      op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o,
  output logic         illegal_o
);

  localparam int unsigned SHW = $clog2(W);

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_SLL: result_o = a_i << b_i[SHW-1:0];
      OP_SLT: result_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
`ifdef REGFILE_EXEC_MUL_EN
      OP_MUL: result_o = '0;
`else
      OP_MUL: illegal_o = 1'b1;
`endif
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_exec_unit.sv
// IDLE/READ/EXEC/WRITE sequencer around the 32 x 64 register file.
// Define REGFILE_EXEC_MUL_EN for a 64-cycle shift-add MUL; otherwise MUL is illegal.
module regfile_exec_unit
  import regfile_pkg::*;
#(
  parameter int unsigned WORDSIZE = regfile_pkg::WORDSIZE,
  parameter int unsigned ADDRW    = regfile_pkg::ADDRW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [2:0]          op,
  input  logic [ADDRW-1:0]    rd,
  input  logic [ADDRW-1:0]    rs1,
  input  logic [ADDRW-1:0]    rs2,
  output logic [ADDRW-1:0]    rf_addr_a,
  output logic [ADDRW-1:0]    rf_addr_b,
  input  logic [WORDSIZE-1:0] rf_data_a,
  input  logic [WORDSIZE-1:0] rf_data_b,
  output logic                rf_write_en,
  output logic [ADDRW-1:0]    rf_write_addr,
  output logic [WORDSIZE-1:0] rf_write_data,
  output logic                done,
  output logic                illegal
);

  exec_state_t         state_q, state_d;
  alu_op_t             op_q;
  logic [ADDRW-1:0]    rd_q, addr_a_q, addr_b_q, wr_addr_q;
  logic [WORDSIZE-1:0] opa_q, opb_q, wr_data_q;
  logic [WORDSIZE-1:0] alu_res, exec_result;
  logic                illegal_q, alu_illegal, exec_last;

  regfile_alu #(.W(WORDSIZE)) u_alu (
    .op_i      (op_q),
    .a_i       (opa_q),
    .b_i       (opb_q),
    .result_o  (alu_res),
    .illegal_o (alu_illegal)
  );

`ifdef REGFILE_EXEC_MUL_EN
  // Operand registers double as multiplicand/multiplier shift registers.
  logic [6:0]          mcnt_q;
  logic [WORDSIZE-1:0] acc_q, acc_step;
  logic                is_mul;
  assign is_mul      = (op_q == OP_MUL);
  assign acc_step    = opb_q[0] ? (acc_q + opa_q) : acc_q;
  assign exec_last   = !is_mul || (mcnt_q == 7'(WORDSIZE - 1));
  assign exec_result = is_mul ? acc_step : alu_res;
`else
  assign exec_last   = 1'b1;
  assign exec_result = alu_res;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  if (exec_last) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gated by rst so a reset in WRITE kills the write in that same cycle.
  assign instr_ready   = (state_q == S_IDLE) && !rst;
  assign done          = (state_q == S_WRITE) && !rst;
  assign illegal       = done && illegal_q;
  assign rf_write_en   = done && !illegal_q && (rd_q != '0);
  assign rf_addr_a     = addr_a_q;
  assign rf_addr_b     = addr_b_q;
  assign rf_write_addr = wr_addr_q;
  assign rf_write_data = wr_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      rd_q      <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      illegal_q <= 1'b0;
`ifdef REGFILE_EXEC_MUL_EN
      acc_q     <= '0;
      mcnt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (instr_valid) begin
          op_q     <= alu_op_t'(op);
          rd_q     <= rd;
          addr_a_q <= rs1;
          addr_b_q <= rs2;
        end
        S_READ: begin
          opa_q <= rf_data_a;
          opb_q <= rf_data_b;
`ifdef REGFILE_EXEC_MUL_EN
          acc_q  <= '0;
          mcnt_q <= '0;
`endif
        end
        S_EXEC: begin
`ifdef REGFILE_EXEC_MUL_EN
          if (is_mul) begin
            acc_q  <= acc_step;
            opa_q  <= opa_q << 1;
            opb_q  <= opb_q >> 1;
            mcnt_q <= mcnt_q + 7'd1;
          end
`endif
          if (exec_last) begin
            wr_addr_q <= rd_q;
            wr_data_q <= exec_result;
            illegal_q <= alu_illegal;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_exec_unit.sv
// Directed bench for regfile_exec_unit with a behavioural 32 x 64 register file.
module tb_regfile_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [63:0] rf_data_a, rf_data_b;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [63:0] rf_write_data;
  logic        done;
  logic        illegal;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  regfile_exec_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .op            (op),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .rf_addr_a     (rf_addr_a),
    .rf_addr_b     (rf_addr_b),
    .rf_data_a     (rf_data_a),
    .rf_data_b     (rf_data_b),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .done          (done),
    .illegal       (illegal)
  );

  // Register file model; the bench-side preload port has priority.
  logic [63:0] rf [32];
  logic        pl_we = 1'b0;
  logic [4:0]  pl_wa = '0;
  logic [63:0] pl_wd = '0;

  always @(posedge clk) begin
    if (pl_we) rf[pl_wa] <= pl_wd;
    else if (rf_write_en) rf[rf_write_addr] <= rf_write_data;
  end
  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic        exp_we;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [63:0] d);
    pl_we = 1'b1; pl_wa = a; pl_wd = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns just after acceptance edge N.
  task automatic accept(input logic [2:0] o, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    op = o; rd = d; rs1 = a; rs2 = b; instr_valid = 1'b1;
    chk("ready_at_issue", {63'd0, instr_ready}, 64'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    accept(v.op, v.rd, v.rs1, v.rs2);
    @(negedge clk);                                   // N+1 READ
    chk("read_addr_a", {59'd0, rf_addr_a}, {59'd0, v.rs1});
    chk("read_addr_b", {59'd0, rf_addr_b}, {59'd0, v.rs2});
    chk("read_done", {63'd0, done}, 64'd0);
    @(negedge clk);                                   // N+2 EXEC
    chk("exec_we", {63'd0, rf_write_en}, 64'd0);
    chk("exec_ready", {63'd0, instr_ready}, 64'd0);
    @(negedge clk);                                   // N+3 WRITE
    chk("write_done", {63'd0, done}, 64'd1);
    chk("write_we", {63'd0, rf_write_en}, {63'd0, v.exp_we});
    chk("write_illegal", {63'd0, illegal}, 64'd0);
    chk("write_data", rf_write_data, v.exp_data);
    if (v.exp_we) chk("write_addr", {59'd0, rf_write_addr}, {59'd0, v.rd});
    @(negedge clk);                                   // N+4
    chk("ready_after", {63'd0, instr_ready}, 64'd1);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    if (v.exp_we) chk("rf_commit", rf[v.rd], v.exp_data);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{3'b000, 5'd13, 5'd4,  5'd6,  1'b1, 64'h8};
    vecs[1]  = '{3'b001, 5'd7,  5'd6,  5'd4,  1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2]  = '{3'b110, 5'd8,  5'd7,  5'd4,  1'b1, 64'h1};
    vecs[3]  = '{3'b000, 5'd0,  5'd4,  5'd6,  1'b0, 64'h8};
    vecs[4]  = '{3'b010, 5'd11, 5'd4,  5'd6,  1'b1, 64'h1};
    vecs[5]  = '{3'b011, 5'd12, 5'd4,  5'd6,  1'b1, 64'h7};
    vecs[6]  = '{3'b100, 5'd15, 5'd4,  5'd6,  1'b1, 64'h6};
    vecs[7]  = '{3'b101, 5'd16, 5'd4,  5'd6,  1'b1, 64'h28};
    vecs[8]  = '{3'b110, 5'd17, 5'd4,  5'd7,  1'b1, 64'h0};
    vecs[9]  = '{3'b101, 5'd18, 5'd4,  5'd20, 1'b1, 64'hA};
    vecs[10] = '{3'b000, 5'd19, 5'd7,  5'd7,  1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[11] = '{3'b110, 5'd22, 5'd6,  5'd4,  1'b1, 64'h1};

    rst = 1'b1; instr_valid = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) preload(5'(i), 64'd0);
    preload(5'd4, 64'h5);
    preload(5'd6, 64'h3);
    preload(5'd20, 64'h41);
    preload(5'd9, 64'h77);
    preload(5'd25, 64'h55);
    preload(5'd26, 64'hE45F_B21F);
    preload(5'd27, 64'h2);

    chk("rst_ready", {63'd0, instr_ready}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_we", {63'd0, rf_write_en}, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_addr_a", {59'd0, rf_addr_a}, 64'd0);
    chk("rst_wdata", rf_write_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_out_of_rst", {63'd0, instr_ready}, 64'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);
    chk("r0_still_zero", rf[0], 64'd0);

    // Held valid: second instruction waits for IDLE and sees r13 freshly written.
    preload(5'd13, 64'd0);
    accept(3'b000, 5'd13, 5'd4, 5'd6);
    instr_valid = 1'b1; rd = 5'd14; rs1 = 5'd13; rs2 = 5'd13;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("b2b_busy", {63'd0, instr_ready}, 64'd0);
      if (c == 1) chk("b2b_first_addr", {59'd0, rf_addr_a}, 64'd4);
      if (c == 3) chk("b2b_first_data", rf_write_data, 64'h8);
    end
    @(negedge clk);
    chk("b2b_ready", {63'd0, instr_ready}, 64'd1);
    chk("b2b_r13", rf[13], 64'h8);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_addr", {59'd0, rf_addr_a}, 64'd13);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_second_we", {63'd0, rf_write_en}, 64'd1);
    chk("b2b_second_addr_w", {59'd0, rf_write_addr}, 64'd14);
    chk("b2b_second_data", rf_write_data, 64'h10);
    @(negedge clk);

    // Reset during EXEC drops the pending write.
    accept(3'b000, 5'd9, 5'd4, 5'd6);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_exec_ready", {63'd0, instr_ready}, 64'd0);
    @(negedge clk);
    chk("rst_exec_done", {63'd0, done}, 64'd0);
    chk("rst_exec_we", {63'd0, rf_write_en}, 64'd0);
    chk("rst_exec_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_exec_addr_a", {59'd0, rf_addr_a}, 64'd0);
    chk("rst_exec_addr_b", {59'd0, rf_addr_b}, 64'd0);
    chk("rst_exec_waddr", {59'd0, rf_write_addr}, 64'd0);
    chk("rst_exec_wdata", rf_write_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_idle", {63'd0, instr_ready}, 64'd1);
    chk("rst_exec_r9", rf[9], 64'h77);

    // Reset in WRITE suppresses the write enable in that same cycle.
    accept(3'b000, 5'd25, 5'd4, 5'd6);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_write_we", {63'd0, rf_write_en}, 64'd0);
    chk("rst_write_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_write_r25", rf[25], 64'h55);
    chk("rst_write_idle", {63'd0, instr_ready}, 64'd1);

    // MUL: latency and outcome depend on the build configuration.
    preload(5'd10, 64'd0);
    accept(3'b111, 5'd10, 5'd26, 5'd27);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
`ifdef REGFILE_EXEC_MUL_EN
    chk("mul_latency", 64'(lat), 64'd66);
    chk("mul_we", {63'd0, rf_write_en}, 64'd1);
    chk("mul_illegal", {63'd0, illegal}, 64'd0);
    chk("mul_data", rf_write_data, 64'h0000_0001_C8BF_643E);
    @(negedge clk);
    chk("mul_r10", rf[10], 64'h0000_0001_C8BF_643E);
`else
    chk("mul_latency", 64'(lat), 64'd3);
    chk("mul_we", {63'd0, rf_write_en}, 64'd0);
    chk("mul_illegal", {63'd0, illegal}, 64'd1);
    @(negedge clk);
    chk("mul_illegal_pulse", {63'd0, illegal}, 64'd0);
    chk("mul_r10", rf[10], 64'd0);
`endif
    chk("mul_ready_after", {63'd0, instr_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_exec_unit.md
# regfile_exec_unit

Sequencing execute stage wrapped around the 32 x 64-bit `register_file`. It accepts one register-register instruction at a time, drives the file's two read ports, computes the result, and writes it back through the file's write port. It is the producer of `write_en`/`write_addr`/`write_data` and the consumer of `data_a`/`data_b`.

## Interface
- `WORDSIZE`, 64, operand/result width; must match the register file.
- `ADDRW`, 5, register address width (32 registers).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction present on `op`/`rd`/`rs1`/`rs2`.
- `instr_ready`  out  1  unit can accept an instruction.
- `op`  in  3  operation code (see Operation).
- `rd`, `rs1`, `rs2`  in  ADDRW each  destination and source registers.
- `rf_addr_a`, `rf_addr_b`  out  ADDRW each  to `addr_a`/`addr_b`.
- `rf_data_a`, `rf_data_b`  in  WORDSIZE each  from `data_a`/`data_b` (combinational read).
- `rf_write_en`  out  1  to `write_en`.
- `rf_write_addr`  out  ADDRW  to `write_addr`.
- `rf_write_data`  out  WORDSIZE  to `write_data`.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse with `done` when the op is not supported.

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE: `instr_ready`=1. On `instr_valid`, latch op/rd/rs1/rs2 and go to READ.
- READ: `rf_addr_a`=rs1, `rf_addr_b`=rs2; capture `rf_data_a`/`rf_data_b` into operand registers; go to EXEC.
- EXEC: compute the result into a result register. Single-cycle ops go to WRITE after 1 cycle.
- WRITE: `rf_write_en`=1 unless rd==0 or the op is illegal; `done`=1; return to IDLE.
- Ops: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SLL (A << B[5:0]), 110 SLT (signed A<B gives 1, otherwise 0), 111 MUL (low 64 bits of A*B).
- All arithmetic is modulo 2^WORDSIZE. Overflow is discarded and no flags are produced.
- rd==0: the result is computed but never written, and `done` still pulses. x0 stays zero by construction.
- `instr_valid` outside IDLE is ignored. The producer holds its instruction until it sees `instr_ready`.

## Timing
- Reset values: state IDLE; `instr_ready`=0 while `rst`=1, then 1; `rf_write_en`=0, `done`=0, `illegal`=0; all address/data outputs 0.
- Single-cycle op accepted at edge N:
  - READ in cycle N+1.
  - EXEC in cycle N+2.
  - WRITE in cycle N+3: the file commits at edge N+4.
  - `instr_ready` is high again in cycle N+4.
- Throughput: one instruction per 4 cycles.
- Back-to-back dependency (write rX, then read rX) needs no forwarding. The write commits before the next READ.
- Outside READ, `rf_addr_a`/`rf_addr_b` hold their last values. Outside WRITE, `rf_write_addr`/`rf_write_data` hold their last values.
- Reset asserted in any state: return to IDLE at that edge and drop any pending write. A reset in WRITE suppresses `rf_write_en` in that same cycle.

## Configuration
- Macro: `REGFILE_EXEC_MUL_EN`.
- Defined: op 111 is an iterative shift-add multiply.
  - A 7-bit counter keeps the FSM in EXEC for 64 cycles, one multiplier bit per cycle.
  - WRITE follows, so MUL latency is 66 cycles from acceptance to WRITE.
- Undefined: op 111 is illegal.
  - EXEC lasts 1 cycle.
  - WRITE pulses `done` and `illegal` with `rf_write_en`=0.
  - No multiplier logic is synthesized.

## Structure
- Shared package `regfile_pkg`:
  - `WORDSIZE`/`ADDRW` constants.
  - op-code localparams/enum `alu_op_t`.
  - FSM state enum `exec_state_t`.
- Sub-module `regfile_alu`: purely combinational, covering the single-cycle ops. The MUL iteration stays in the top block, next to the FSM counter.

## Test plan
- Preload r4=0x5, r6=0x3 (via the file's write port). Issue ADD rd=13, rs1=4, rs2=6. Expect a write of 0x8 to r13 in cycle N+3, `done` pulsing once, and `instr_ready` high in N+4.
- SUB rd=7, r6-r4 = 3-5 -> r7=0xFFFF_FFFF_FFFF_FFFE. Then SLT rd=8, rs1=7, rs2=4 -> r8=1.
- ADD rd=0, rs1=4, rs2=6:
  - Expect `rf_write_en` to stay 0 and `done` to pulse.
  - A subsequent read of r0 returns 0.
- Hold `instr_valid` high with two different instructions back-to-back. The second is accepted only in cycle N+4 and sees the first instruction's result (r13 written, then ADD rd=14, rs1=13, rs2=13 -> r14=0x10).
- Assert `rst` during EXEC of ADD rd=9. Expect no write to r9, FSM in IDLE, and all outputs at reset values.
- MUL 0x0000_0000_e45f_b21f * 0x2 into rd=10:
  - With `REGFILE_EXEC_MUL_EN`: r10=0x0000_0001_c8bf_643e after 66 cycles.
  - Without it: `illegal` pulses, there is no write, and latency is 3 cycles.
